// File: rtl/vz_saver_if.sv
// MiSTer ioctl upload bus between hps_io (master) and the VZ saver (slave).
interface vz_saver_if;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic [24:0] upload_size;

    modport master (
        output ioctl_upload, ioctl_rd, ioctl_addr,
        input  ioctl_din, upload_size
    );

    modport slave (
        input  ioctl_upload, ioctl_rd, ioctl_addr,
        output ioctl_din, upload_size
    );
endinterface

// File: rtl/vz_saver.sv
// Streams the resident VZ program back to the host as a .vz file:
// 24-byte generated header followed by the program body read from RAM.
module vz_saver #(
    parameter int unsigned HDR_LEN  = 24,
    parameter logic [15:0] SV_START = 16'h78A4,
    parameter logic [15:0] SV_END   = 16'h78F9
) (
    input  logic        I_CLK,
    input  logic        I_RST,
    vz_saver_if.slave   io,
    input  logic [7:0]  save_mode,
    input  logic [15:0] mc_start,
    input  logic [15:0] mc_end,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic        ready,
    output logic        led
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PTR   = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    localparam logic [7:0]  MODE_MC   = 8'hF1;
    localparam logic [24:0] HDR_LEN_W = 25'(HDR_LEN);
    localparam logic [15:0] HDR_LEN_A = 16'(HDR_LEN);

    state_t      state_r;
    logic        upload_prev_r;
    logic [2:0]  cnt_r;
    logic        mode_mc_r;
    logic [15:0] start_r;
    logic [15:0] end_r;
    logic [7:0]  din_r;
    logic [15:0] mem_addr_r;
    logic        mem_rd_r;
    logic [24:0] size_r;
    logic        ready_r;
    logic        p1_v_r, p1_body_r;
    logic [7:0]  p1_byte_r;
    logic        p2_v_r, p2_body_r;
    logic [7:0]  p2_byte_r;

    logic        upload_rise_s;
    logic [15:0] end_full_s;
    logic [15:0] len_s;
    logic        in_hdr_s;
    logic        in_body_s;
    logic [7:0]  hdr_s;
    logic [15:0] body_addr_s;

    function automatic logic [7:0] hdr_byte(input logic [4:0] idx, input logic mc,
                                            input logic [15:0] st);
        case (idx)
            5'd0:    hdr_byte = 8'h56;
            5'd1:    hdr_byte = 8'h5A;
            5'd2:    hdr_byte = 8'h46;
            5'd3:    hdr_byte = 8'h30;
            5'd4:    hdr_byte = 8'h4D;
            5'd5:    hdr_byte = 8'h49;
            5'd6:    hdr_byte = 8'h53;
            5'd7:    hdr_byte = 8'h54;
            5'd8:    hdr_byte = 8'h45;
            5'd9:    hdr_byte = 8'h52;
            5'd21:   hdr_byte = mc ? 8'hF1 : 8'hF0;
            5'd22:   hdr_byte = st[7:0];
            5'd23:   hdr_byte = st[15:8];
            default: hdr_byte = 8'h00;
        endcase
    endfunction

    // Request decode; the end pointer's high byte arrives on mem_data in the last PTR cycle.
    always_comb begin
        upload_rise_s = io.ioctl_upload & ~upload_prev_r;
        if (mode_mc_r) begin
            end_full_s = end_r;
        end else begin
            end_full_s = {mem_data, end_r[7:0]};
        end
        if (end_full_s > start_r) begin
            len_s = end_full_s - start_r;
        end else begin
            len_s = 16'd0;
        end
        in_hdr_s = (io.ioctl_addr < HDR_LEN_W);
        if (in_hdr_s) begin
            in_body_s = 1'b0;
            hdr_s     = hdr_byte(io.ioctl_addr[4:0], mode_mc_r, start_r);
        end else begin
            in_body_s = (io.ioctl_addr < size_r);
            hdr_s     = 8'h00;
        end
        body_addr_s = start_r + io.ioctl_addr[15:0] - HDR_LEN_A;
    end

    // Session FSM, pointer fetch and the two-stage read pipeline.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_r       <= ST_IDLE;
            upload_prev_r <= 1'b0;
            cnt_r         <= 3'd0;
            mode_mc_r     <= 1'b0;
            start_r       <= 16'd0;
            end_r         <= 16'd0;
            din_r         <= 8'h00;
            mem_addr_r    <= 16'd0;
            mem_rd_r      <= 1'b0;
            size_r        <= 25'd0;
            ready_r       <= 1'b0;
            p1_v_r        <= 1'b0;
            p1_body_r     <= 1'b0;
            p1_byte_r     <= 8'h00;
            p2_v_r        <= 1'b0;
            p2_body_r     <= 1'b0;
            p2_byte_r     <= 8'h00;
        end else begin
            upload_prev_r <= io.ioctl_upload;
            if (!io.ioctl_upload) begin
                // Session over: drop in-flight reads, keep din and size.
                state_r  <= ST_IDLE;
                ready_r  <= 1'b0;
                mem_rd_r <= 1'b0;
                p1_v_r   <= 1'b0;
                p2_v_r   <= 1'b0;
            end else if (upload_rise_s) begin
                state_r   <= ST_PTR;
                cnt_r     <= 3'd1;
                ready_r   <= 1'b0;
                p1_v_r    <= 1'b0;
                p2_v_r    <= 1'b0;
                mode_mc_r <= (save_mode == MODE_MC);
                if (save_mode == MODE_MC) begin
                    start_r  <= mc_start;
                    end_r    <= mc_end;
                    mem_rd_r <= 1'b0;
                end else begin
                    mem_rd_r   <= 1'b1;
                    mem_addr_r <= SV_START;
                end
            end else begin
                case (state_r)
                    ST_PTR: begin
                        cnt_r <= cnt_r + 3'd1;
                        case (cnt_r)
                            3'd1: begin
                                mem_addr_r <= SV_START + 16'd1;
                            end
                            3'd2: begin
                                mem_addr_r <= SV_END;
                                if (!mode_mc_r) start_r[7:0] <= mem_data;
                            end
                            3'd3: begin
                                mem_addr_r <= SV_END + 16'd1;
                                if (!mode_mc_r) start_r[15:8] <= mem_data;
                            end
                            3'd4: begin
                                mem_rd_r <= 1'b0;
                                if (!mode_mc_r) end_r[7:0] <= mem_data;
                            end
                            3'd5: begin
                                end_r   <= end_full_s;
                                size_r  <= HDR_LEN_W + {9'd0, len_s};
                                ready_r <= 1'b1;
                                state_r <= ST_SERVE;
                            end
                            default: begin
                                mem_rd_r <= 1'b0;
                            end
                        endcase
                    end
                    ST_SERVE: begin
                        if (p2_v_r) din_r <= p2_body_r ? mem_data : p2_byte_r;
                        p2_v_r    <= p1_v_r;
                        p2_body_r <= p1_body_r;
                        p2_byte_r <= p1_byte_r;
                        p1_v_r    <= io.ioctl_rd;
                        p1_body_r <= in_body_s;
                        p1_byte_r <= hdr_s;
                        mem_rd_r  <= io.ioctl_rd & in_body_s;
                        if (io.ioctl_rd && in_body_s) mem_addr_r <= body_addr_s;
                    end
                    default: begin
                        mem_rd_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io.ioctl_din   = din_r;
    assign io.upload_size = size_r;
    assign mem_addr       = mem_addr_r;
    assign mem_rd         = mem_rd_r;
    assign ready          = ready_r;
    assign led            = ready_r;

endmodule

// File: doc/vz_saver.md
Name: vz_saver

Overview:
- Other direction of the VZ program loader: streams the resident program back out as a .vz file over the MiSTer ioctl upload interface.
- On upload start, fetches the program start/end pointers, then serves host read requests.
- Byte 0-23: generated VZ header. Byte 24 onward: program body read from system RAM.
- Sits between hps_io (upload side) and the RAM arbiter, which owns CPU-vs-saver access.

Parameters:
- HDR_LEN, 24, header length in bytes (fixed file format).
- SV_START, 16'h78A4, address of BASIC program-start pointer (lo byte; hi byte at +1).
- SV_END, 16'h78F9, address of BASIC program-end pointer (lo byte; hi byte at +1).

Ports:
- I_CLK  in  1  system clock
- I_RST  in  1  synchronous active-high reset
- ioctl_upload  in  1  high for the whole upload session
- ioctl_rd  in  1  one-cycle read strobe from host
- ioctl_addr  in  25  file byte offset of the read
- ioctl_din  out  8  read data to host
- save_mode  in  8  8'hF1 = machine code; any other value = BASIC (F0)
- mc_start  in  16  machine-code block start (mode F1)
- mc_end  in  16  machine-code block end, exclusive (mode F1)
- mem_addr  out  16  RAM read address
- mem_rd  out  1  RAM read strobe; data is returned on mem_data the following cycle
- mem_data  in  8  RAM read data
- upload_size  out  25  total file length
- ready  out  1  pointers valid; host reads are being served
- led  out  1  activity indicator, equal to ready

Behaviour:
- Reset (synchronous, any state): ioctl_din=0, mem_addr=0, mem_rd=0, upload_size=0, ready=0, led=0, state=IDLE. Any in-flight read is discarded.
- Upload start is detected on a rising edge of ioctl_upload, using a registered previous sample. The detect cycle is cycle 0.
- IDLE: waits for upload start, then moves to PTR.
- PTR, BASIC mode:
  - Cycles 1-4: mem_rd=1 with mem_addr = SV_START, SV_START+1, SV_END, SV_END+1.
  - Bytes are captured in cycles 2-5 into start[7:0], start[15:8], end[7:0], end[15:8].
- PTR, mode F1:
  - start=mc_start, end=mc_end; mem_rd stays 0.
  - Timing is identical to BASIC mode.
- Cycle 6: length computed, upload_size = HDR_LEN + length, ready=1, state=SERVE.
  - length = end-start when end > start (unsigned), else 0.
- save_mode is sampled at cycle 0 only. start, end and mode are frozen for the rest of the session.
- SERVE: each ioctl_rd sampled at cycle t returns ioctl_din at cycle t+2 (fixed latency for every region).
  - Header, addr 0-3: 8'h56, 8'h5A, 8'h46, 8'h30 ("VZF0").
  - Header, addr 4-20: name "MISTER" (8'h4D,49,53,54,45,52), then 8'h00 pad.
  - Header, addr 21: type, F1 or F0.
  - Header, addr 22-23: start[7:0], then start[15:8].
  - Body, HDR_LEN <= addr < upload_size: mem_addr = start + (addr-HDR_LEN) mod 2^16, mem_rd=1 at t+1, ioctl_din <= mem_data at t+2.
  - Beyond, addr >= upload_size: 8'h00, no mem_rd.
- Back-to-back ioctl_rd on every cycle is supported and fully pipelined; results come out in request order.
- ioctl_rd outside SERVE is ignored: ioctl_din holds, no mem_rd.
- mem_rd is a single-cycle pulse per body read. It is never asserted in IDLE or after upload ends.
- ioctl_upload falling in any state:
  - Next cycle: ready=0, led=0, state=IDLE.
  - Pending reads are dropped; ioctl_din holds its last value.
  - upload_size holds until the next session.
- ioctl_upload rising again starts a fresh session and re-fetches the pointers.

Test Plan:
- BASIC: RAM[78A4..78A5]=E9,7A; RAM[78F9..78FA]=F9,7A; upload rises. Expect mem_rd at cycles 1-4 to 78A4, 78A5, 78F9, 78FA; ready=1 at cycle 6; upload_size=40; reads of addr 21, 22, 23 return F0, E9, 7A.
- Body stream: same setup, RAM[7AE9+i]=i, ioctl_rd every cycle for addr 24-39. Expect mem_addr 7AE9..7AF8 and ioctl_din 00..0F, each arriving 2 cycles after its rd.
- Header and overrun: read addr 0-3 -> 56, 5A, 46, 30; addr 4 -> 4D; addr 10 -> 00; addr 40 and addr 100 -> 00 with no mem_rd.
- Machine code: save_mode=F1, mc_start=8000, mc_end=8000. Expect no mem_rd in PTR; upload_size=24; addr 21 -> F1; addr 22/23 -> 00/80.
- Degenerate range: BASIC with end=7000, start=7AE9 -> upload_size=24.
- Abort/reset: drop ioctl_upload with a read in flight -> ready=0 next cycle, no further mem_rd. Assert I_RST mid-SERVE -> all outputs return to 0 next cycle. A new upload rise re-fetches the pointers.
